// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for a Rijndael datapath (NB = 4/6/8 columns).
// The transform is applied at capture into a 2-entry FIFO, whose head drives the outputs.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [32*NB-1:0]    in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rijndael row offsets: rows 2 and 3 shift one further for the 256-bit block.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) begin
      return r + 1;
    end else begin
      return r;
    end
  endfunction

  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] o;
    int           src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (inv) begin
          src = (c - row_shift(r) + NB) % NB;
        end else begin
          src = (c + row_shift(r)) % NB;
        end
        o[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [1:0]       count;
  logic [W-1:0]     data0;
  logic [W-1:0]     data1;
  logic [TAG_W-1:0] tag0;
  logic [TAG_W-1:0] tag1;
  logic [W-1:0]     cap_data;
  logic             push;
  logic             pop;

  // Handshake qualification and the capture-side transform.
  always_comb begin
    cap_data = shift_rows(in_data, in_inv);
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = data0;
  assign out_tag   = tag0;

  // FIFO storage and occupancy; entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      tag0  <= '0;
      tag1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= cap_data;
            tag0  <= in_tag;
          end else begin
            data1 <= cap_data;
            tag1  <= in_tag;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          tag0  <= tag1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // With one entry the new state replaces the head directly.
          if (count == 2'd1) begin
            data0 <= cap_data;
            tag0  <= in_tag;
          end else begin
            data0 <= data1;
            tag0  <= tag1;
            data1 <= cap_data;
            tag1  <= in_tag;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench: NB=4 and NB=8 instances share one control stream and are
// compared against a queue-based FIFO model with row-rotation reference transform.
module tb_shift_rows_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic         out_ready;
  logic [3:0]   in_tag;
  logic [127:0] in_data4;
  logic [255:0] in_data8;
  logic         in_ready4, in_ready8;
  logic         out_valid4, out_valid8;
  logic [127:0] out_data4;
  logic [255:0] out_data8;
  logic [3:0]   out_tag4, out_tag8;

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic [255:0] d4;
    logic [255:0] d8;
    logic [3:0]   tag;
  } ent_t;
  ent_t mq[$];

  localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_FWD = 128'h0055aaff4499ee3388dd2277cc1166bb;
  localparam logic [127:0] VEC_INV = 128'h00ddaa774411eebb885522ffcc996633;
  localparam logic [255:0] VEC_ASC =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_inv(in_inv), .in_data(in_data4), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_tag(out_tag4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_inv(in_inv), .in_data(in_data8), .in_tag(in_tag),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_tag(out_tag8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each row is rotated as a byte queue by its offset.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    logic [7:0]   row[$];
    int           offs[4];
    int           w;
    w = 32 * nb;
    o = '0;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row = {};
      for (int c = 0; c < nb; c++) row.push_back(d[w-1-8*(4*c+r) -: 8]);
      repeat (offs[r]) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[w-1-8*(4*c+r) -: 8] = row[c];
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    ntot++;
  endtask

  // Compare both DUTs against the model, advance one clock, update the model.
  task automatic step();
    bit   mready;
    bit   push;
    bit   pop;
    ent_t e;
    mready = (mq.size() != 2);
    push   = in_valid && mready;
    pop    = (mq.size() != 0) && out_ready;
    check("in_ready4", {255'd0, in_ready4}, {255'd0, mready});
    check("in_ready8", {255'd0, in_ready8}, {255'd0, mready});
    check("out_valid4", {255'd0, out_valid4}, {255'd0, mq.size() != 0});
    check("out_valid8", {255'd0, out_valid8}, {255'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("out_data4", {128'd0, out_data4}, mq[0].d4);
      check("out_data8", out_data8, mq[0].d8);
      check("out_tag4", {252'd0, out_tag4}, {252'd0, mq[0].tag});
      check("out_tag8", {252'd0, out_tag8}, {252'd0, mq[0].tag});
    end
    e.d4  = ref_shift({128'd0, in_data4}, 4, in_inv);
    e.d8  = ref_shift(in_data8, 8, in_inv);
    e.tag = in_tag;
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) in_data4[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) in_data8[32*i +: 32] = $urandom;
    in_tag = 4'($urandom_range(0, 15));
  endtask

  initial begin
    bit acc;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
    in_tag = 4'd0; in_data4 = '0; in_data8 = '0;
    #12;
    check("rst_valid", {255'd0, out_valid4}, 256'd0);
    check("rst_ready", {255'd0, in_ready4}, 256'd1);
    check("rst_data4", {128'd0, out_data4}, 256'd0);
    check("rst_tag4", {252'd0, out_tag4}, 256'd0);
    check("rst_data8", out_data8, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // NB=4 forward, then inverse, then inverse result fed back forward.
    in_valid = 1'b1; in_inv = 1'b0; in_data4 = VEC_IN; in_tag = 4'd1;
    step();
    check("fwd4_vec", {128'd0, out_data4}, {128'd0, VEC_FWD});
    in_valid = 1'b0;
    step();
    check("fwd4_one_cycle", {255'd0, out_valid4}, 256'd0);
    in_valid = 1'b1; in_inv = 1'b1; in_data4 = VEC_IN; in_tag = 4'd2;
    step();
    check("inv4_vec", {128'd0, out_data4}, {128'd0, VEC_INV});
    in_inv = 1'b0; in_data4 = VEC_INV; in_tag = 4'd3;
    step();
    check("roundtrip4", {128'd0, out_data4}, {128'd0, VEC_IN});
    in_valid = 1'b0;
    step();

    // NB=8 forward on ascending bytes.
    in_valid = 1'b1; in_inv = 1'b0; in_data8 = VEC_ASC; in_tag = 4'd4;
    step();
    check("fwd8_col0", {224'd0, out_data8[255:224]}, {224'd0, 32'h00050e13});
    check("fwd8_col7", {224'd0, out_data8[31:0]}, {224'd0, 32'h1c010a0f});
    in_valid = 1'b0;
    step();

    // Backpressure: two accepted, third held until space frees.
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); in_tag = 4'd1; step();
    randomize_inputs(); in_tag = 4'd2; step();
    randomize_inputs(); in_tag = 4'd3;
    check("bp_full", {255'd0, in_ready4}, 256'd0);
    step(); step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step(); step();

    // Full-rate streaming with push+pop at count 1.
    in_valid = 1'b1;
    repeat (6) begin
      randomize_inputs(); in_inv = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Reset asserted between edges while full.
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); step();
    randomize_inputs(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {255'd0, out_valid4}, 256'd0);
    check("rst_mid_ready", {255'd0, in_ready4}, 256'd1);
    check("rst_mid_data4", {128'd0, out_data4}, 256'd0);
    check("rst_mid_data8", out_data8, 256'd0);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1; randomize_inputs();
    step();
    in_valid = 1'b0;
    step();

    // Mixed modes with random downstream readiness; each state held until accepted.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_inv = 1'(i % 2); randomize_inputs(); in_tag = 4'(i + 4);
      guard = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        acc = (mq.size() != 2);
        step();
        guard++;
      end while (!acc && guard < 50);
      check("mixed_accept", {255'd0, acc}, 256'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Random soak, including changing data while idle.
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      randomize_inputs();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered ShiftRows / InvShiftRows unit for the Rijndael datapath.
- Supports block widths of 128, 192 and 256 bits (NB = 4/6/8 columns) and a per-transaction forward/inverse select.
- Uses a valid/ready handshake with a 2-entry output buffer, so it can sit between SubBytes and MixColumns stages under backpressure.
- Carries an opaque sideband tag alongside each state.

Parameters:
- NB, 4, number of 32-bit state columns; legal values are 4, 6 and 8; any other value is an elaboration error.
- TAG_W, 4, width of the sideband tag carried with each state (minimum 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state present
- in_ready  output  1  unit can accept this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
- in_data  input  32*NB  state, column-major, byte 0 at the MSB
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  output entry present
- out_ready  input  1  downstream accepts
- out_data  output  32*NB  transformed state
- out_tag  output  TAG_W  tag of the head entry

Behaviour:
- Byte map:
  - Let W = 32*NB. The byte at row r (0..3), column c (0..NB-1) sits at bits [W-1-8*(4c+r) -: 8].
  - Row shift offsets are shift = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
- Forward (in_inv=0): out(r,c) = in(r, (c+shift_r) mod NB).
- Inverse (in_inv=1): out(r,c) = in(r, (c-shift_r) mod NB).
- The transform is combinational on the input side and is applied at capture. Buffer entries hold transformed data plus tag.
- Buffer: 2-entry FIFO, head at entry 0, occupancy count in {0,1,2}.
  - Push: in_valid && in_ready.
  - Pop: out_valid && out_ready.
- in_ready = (count != 2). It is driven from registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data and out_tag show the head entry.
- Latency: a state accepted at edge k is presented on out_* immediately after edge k when the buffer was empty. That is 1 cycle, and throughput is 1 per cycle while out_ready stays high.
- Simultaneous events:
  - count=0, push: count becomes 1; the new entry becomes head.
  - count=1, push and pop: count stays 1; the head is replaced by the new entry.
  - count=1, push only: count becomes 2; the new entry goes to slot 1.
  - count=2, pop only: slot 1 moves to head; count becomes 1. No push is possible because in_ready=0.
  - count=2, out_ready low: all outputs hold stable and in_ready=0.
- Order: strictly FIFO. in_inv affects only its own transaction, and mixed modes back-to-back are legal.
- Upstream data and tag may change freely while in_valid=0; they are ignored.
- Reset, asynchronous assertion at any time including mid-stall: count=0, out_valid=0, in_ready=1, out_data=0, out_tag=0, all entries cleared.
  - Reset release is synchronous to clk.
  - No transaction is accepted on the first edge after release unless in_valid is high at that edge.
- Values of out_data when out_valid=0 are don't-care after the first pop, but must not be X.

Test Plan:
- NB=4, forward. in_data=00112233445566778899aabbccddeeff, out_ready=1 -> next cycle out_data=0055aaff4499ee3388dd2277cc1166bb, out_valid for 1 cycle.
- NB=4, inverse. Same input, in_inv=1 -> out_data=00ddaa774411eebb885522ffcc996633. Feeding this back with in_inv=0 returns the original state.
- NB=8, forward. in_data bytes 00..1f ascending -> column 0 of out_data = 00 05 0e 13, and column 7 = 1c 01 0a 0f.
- Backpressure:
  - Hold out_ready=0 and present 3 states with tags 1,2,3.
  - Required: the first two are accepted, then in_ready=0 and the third is held.
  - Release out_ready: out_tag sequence is 1,2,3, with no loss or duplication.
  - Count=1 push+pop: throughput stays 1/cycle.
- Reset mid-stall: with count=2, assert rst_n low between edges -> out_valid=0, in_ready=1, out_data=0 immediately. After release, the first new state emerges with the correct transform.
- Mixed modes: alternate in_inv 0/1 on 8 random states with random out_ready -> every output matches the scoreboard model per tag.
